// File: rtl/z80_bus_responder.sv
// Z80 bus responder: zero-wait internal RAM below 2^INT_BITS, external accesses
// forwarded over a req/ack port while the core is held, with a timeout watchdog.
module z80_bus_responder #(
    parameter int INT_BITS = 14,
    parameter int TIMEOUT  = 255
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  DO,
    input  logic        W,
    output logic [7:0]  DI,
    output logic        HOLD,
    output logic [15:0] M_ADDR,
    output logic [7:0]  M_WDATA,
    output logic        M_WE,
    output logic        M_REQ,
    input  logic [7:0]  M_RDATA,
    input  logic        M_ACK,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int          RAM_DEPTH = 1 << INT_BITS;
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          di_q, di_d;
    logic [15:0]         maddr_q, maddr_d;
    logic [7:0]          mwdata_q, mwdata_d;
    logic                mwe_q, mwe_d;
    logic                mreq_q, mreq_d;
    logic                err_q, err_d;
    logic [15:0]         wd_q, wd_d;
    logic [7:0]          cap_q, cap_d;
    logic [7:0]          ram_q [RAM_DEPTH];
    logic                ram_we;
    logic                hold_int;
    logic                is_ext;
    logic [INT_BITS-1:0] ram_idx;

    assign is_ext  = (A[15:INT_BITS] != '0);
    assign ram_idx = A[INT_BITS-1:0];

    always_comb begin
        state_d  = state_q;
        di_d     = di_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwe_d    = mwe_q;
        mreq_d   = mreq_q;
        err_d    = err_q;
        wd_d     = wd_q;
        cap_d    = cap_q;
        ram_we   = 1'b0;
        hold_int = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_ext) begin
                    maddr_d  = A;
                    mwdata_d = DO;
                    mwe_d    = W;
                    mreq_d   = 1'b1;
                    wd_d     = '0;
                    state_d  = S_WAIT;
                end else begin
                    // Write-through: the core sees its own write data on DI.
                    hold_int = 1'b1;
                    ram_we   = W & ~RESET;
                    di_d     = W ? DO : ram_q[ram_idx];
                end
            end
            S_WAIT: begin
                if (M_ACK) begin
                    cap_d   = mwe_q ? mwdata_q : M_RDATA;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    cap_d   = 8'hFF;
                    err_d   = 1'b1;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_DONE: begin
                // Core advances at this edge, so the address cannot be re-requested.
                hold_int = 1'b1;
                di_d     = cap_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            di_q     <= 8'h00;
            maddr_q  <= 16'h0000;
            mwdata_q <= 8'h00;
            mwe_q    <= 1'b0;
            mreq_q   <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= 16'h0000;
            cap_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            di_q     <= di_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwe_q    <= mwe_d;
            mreq_q   <= mreq_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
            cap_q    <= cap_d;
        end
    end

    // RAM is deliberately not reset; contents survive RESET.
    always_ff @(posedge CLOCK) begin
        if (ram_we) begin
            ram_q[ram_idx] <= DO;
        end
    end

    assign HOLD    = hold_int & ~RESET;
    assign DI      = di_q;
    assign M_ADDR  = maddr_q;
    assign M_WDATA = mwdata_q;
    assign M_WE    = mwe_q;
    assign M_REQ   = mreq_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: table of accesses plus hand-written
// reset-during-wait and timeout sequences.
module tb_z80_bus_responder;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        w;
        int          ack;
        logic [7:0]  rdata;
        logic [7:0]  exp_di;
        int          exp_stall;
        int          exp_req;
    } vec_t;

    logic        CLOCK = 1'b0;
    logic        RESET, W, M_ACK, HOLD, M_WE, M_REQ, ERR;
    logic [15:0] A, M_ADDR;
    logic [7:0]  DO, DI, M_WDATA, M_RDATA;

    logic        t_rst, t_w, t_ack, t_hold, t_mwe, t_mreq, t_err;
    logic [15:0] t_a, t_maddr;
    logic [7:0]  t_do, t_di, t_mwdata, t_rdata;

    int total = 0;
    int bad   = 0;

    always #5 CLOCK = ~CLOCK;

    z80_bus_responder #(.INT_BITS(14), .TIMEOUT(8)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .A(A), .DO(DO), .W(W), .DI(DI), .HOLD(HOLD),
        .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_WE(M_WE), .M_REQ(M_REQ),
        .M_RDATA(M_RDATA), .M_ACK(M_ACK), .ERR(ERR)
    );

    z80_bus_responder #(.INT_BITS(14), .TIMEOUT(4)) dut_to (
        .CLOCK(CLOCK), .RESET(t_rst), .A(t_a), .DO(t_do), .W(t_w), .DI(t_di), .HOLD(t_hold),
        .M_ADDR(t_maddr), .M_WDATA(t_mwdata), .M_WE(t_mwe), .M_REQ(t_mreq),
        .M_RDATA(t_rdata), .M_ACK(t_ack), .ERR(t_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic run_acc(input vec_t v, input string nm);
        int   stall, reqc, rises, guard;
        logic prev, acc;
        A = v.addr; DO = v.wdata; W = v.w; M_ACK = 1'b0;
        stall = 0; reqc = 0; rises = 0; guard = 0; prev = 1'b0; acc = 1'b0;
        while (!acc && guard < 40) begin
            if (M_REQ) begin
                reqc++;
                if (!prev) rises++;
                check({nm, ".m_addr"}, 32'(M_ADDR), 32'(v.addr));
                check({nm, ".m_wdata"}, 32'(M_WDATA), 32'(v.wdata));
                check({nm, ".m_we"}, 32'(M_WE), 32'(v.w));
                if (reqc == v.ack) begin
                    M_ACK = 1'b1; M_RDATA = v.rdata;
                end else begin
                    M_ACK = 1'b0;
                end
            end else begin
                M_ACK = 1'b0;
            end
            prev = M_REQ;
            #1;
            if (HOLD) acc = 1'b1;
            else stall++;
            @(negedge CLOCK);
            guard++;
        end
        M_ACK = 1'b0;
        if (!acc) check({nm, ".bound"}, 32'd0, 32'd1);
        check({nm, ".di"}, 32'(DI), 32'(v.exp_di));
        check({nm, ".stall"}, 32'(stall), 32'(v.exp_stall));
        check({nm, ".req_cycles"}, 32'(reqc), 32'(v.exp_req));
        check({nm, ".req_rises"}, 32'(rises), (v.exp_req > 0) ? 32'd1 : 32'd0);
        check({nm, ".m_req_end"}, 32'(M_REQ), 32'd0);
        check({nm, ".m_we_end"}, 32'(M_WE), 32'd0);
        check({nm, ".err"}, 32'(ERR), 32'd0);
    endtask

    task automatic t_access(input logic [15:0] addr, input logic [7:0] wd, input logic w,
                            input int ack, input logic [7:0] rd,
                            output int stall, output int reqc);
        int   guard;
        logic acc;
        t_a = addr; t_do = wd; t_w = w; t_ack = 1'b0;
        stall = 0; reqc = 0; guard = 0; acc = 1'b0;
        while (!acc && guard < 40) begin
            if (t_mreq) begin
                reqc++;
                t_ack = (reqc == ack);
                t_rdata = rd;
            end else begin
                t_ack = 1'b0;
            end
            #1;
            if (t_hold) acc = 1'b1;
            else stall++;
            @(negedge CLOCK);
            guard++;
        end
        t_ack = 1'b0;
        if (!acc) check("to.bound", 32'd0, 32'd1);
    endtask

    vec_t vecs[0:9];
    vec_t rv;
    int   st, rq;

    initial begin
        RESET = 1'b1; A = 16'h0000; DO = 8'h00; W = 1'b0; M_ACK = 1'b0; M_RDATA = 8'h00;
        t_rst = 1'b1; t_a = 16'h0000; t_do = 8'h00; t_w = 1'b0; t_ack = 1'b0; t_rdata = 8'h00;

        //          addr      wdata  w     ack rdata  exp_di stall req
        vecs[0] = '{16'h1234, 8'h5A, 1'b1, 0, 8'h00, 8'h5A, 0, 0};
        vecs[1] = '{16'h1234, 8'h00, 1'b0, 0, 8'h00, 8'h5A, 0, 0};
        vecs[2] = '{16'h8000, 8'h00, 1'b0, 1, 8'hC3, 8'hC3, 2, 1};
        vecs[3] = '{16'hF00F, 8'h77, 1'b1, 5, 8'h99, 8'h77, 6, 5};
        vecs[4] = '{16'h4000, 8'h00, 1'b0, 1, 8'h11, 8'h11, 2, 1};
        vecs[5] = '{16'h3FFF, 8'hA5, 1'b1, 0, 8'h00, 8'hA5, 0, 0};
        vecs[6] = '{16'h3FFF, 8'h00, 1'b0, 0, 8'h00, 8'hA5, 0, 0};
        vecs[7] = '{16'hC000, 8'h00, 1'b0, 8, 8'h42, 8'h42, 9, 8};
        vecs[8] = '{16'h0010, 8'h21, 1'b1, 0, 8'h00, 8'h21, 0, 0};
        vecs[9] = '{16'h0011, 8'h34, 1'b1, 0, 8'h00, 8'h34, 0, 0};

        repeat (2) @(negedge CLOCK);
        #1;
        check("rst.di", 32'(DI), 32'h00);
        check("rst.hold", 32'(HOLD), 32'd0);
        check("rst.m_req", 32'(M_REQ), 32'd0);
        check("rst.m_we", 32'(M_WE), 32'd0);
        check("rst.m_addr", 32'(M_ADDR), 32'h0000);
        check("rst.m_wdata", 32'(M_WDATA), 32'h00);
        check("rst.err", 32'(ERR), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0; t_rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_acc(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) check("vec0.di_hold", 32'(DI), 32'h5A);
        end

        // Alternating internal/external reads with random ack delays.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                rv.w = 1'b0; rv.wdata = 8'h00;
                if (k % 2 == 0) begin
                    rv.addr = (k == 0) ? 16'h0010 : 16'h0011;
                    rv.ack = 0; rv.rdata = 8'h00;
                    rv.exp_di = (k == 0) ? 8'h21 : 8'h34;
                    rv.exp_stall = 0; rv.exp_req = 0;
                end else begin
                    rv.addr = (k == 1) ? 16'h9000 : 16'h9001;
                    rv.ack = int'($urandom_range(1, 8));
                    rv.rdata = 8'($urandom_range(0, 255));
                    rv.exp_di = rv.rdata;
                    rv.exp_stall = rv.ack + 1; rv.exp_req = rv.ack;
                end
                run_acc(rv, $sformatf("alt%0d_%0d", r, k));
            end
        end

        // Reset in the second WAIT cycle, then a late ACK while idle.
        run_acc('{16'hE000, 8'h00, 1'b0, 1, 8'h5C, 8'h5C, 2, 1}, "pre_rst");
        A = 16'hB000; W = 1'b0; DO = 8'h00;
        @(negedge CLOCK);
        check("mw.req_w1", 32'(M_REQ), 32'd1);
        @(negedge CLOCK);
        check("mw.req_w2", 32'(M_REQ), 32'd1);
        RESET = 1'b1;
        #1 check("mw.hold_rst", 32'(HOLD), 32'd0);
        @(negedge CLOCK);
        check("mw.req_after", 32'(M_REQ), 32'd0);
        check("mw.di_after", 32'(DI), 32'h00);
        check("mw.hold_in_rst", 32'(HOLD), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0; A = 16'h0010; M_ACK = 1'b1; M_RDATA = 8'h66;
        #1 check("mw.hold_idle", 32'(HOLD), 32'd1);
        @(negedge CLOCK);
        M_ACK = 1'b0;
        check("mw.late_ack_di", 32'(DI), 32'h21);
        check("mw.late_ack_req", 32'(M_REQ), 32'd0);
        check("mw.err", 32'(ERR), 32'd0);

        // Timeout on the TIMEOUT=4 instance; ERR must stick until reset.
        t_access(16'hA000, 8'h00, 1'b0, 0, 8'h00, st, rq);
        check("to.stall", 32'(st), 32'd5);
        check("to.req_cycles", 32'(rq), 32'd4);
        check("to.di", 32'(t_di), 32'hFF);
        check("to.err", 32'(t_err), 32'd1);
        check("to.m_req", 32'(t_mreq), 32'd0);
        t_access(16'h0100, 8'h3C, 1'b1, 0, 8'h00, st, rq);
        check("to.int_stall", 32'(st), 32'd0);
        check("to.int_di", 32'(t_di), 32'h3C);
        check("to.err_int", 32'(t_err), 32'd1);
        t_access(16'hA001, 8'h00, 1'b0, 2, 8'h81, st, rq);
        check("to.ext_stall", 32'(st), 32'd3);
        check("to.ext_di", 32'(t_di), 32'h81);
        check("to.err_ext", 32'(t_err), 32'd1);
        t_rst = 1'b1;
        @(negedge CLOCK);
        t_rst = 1'b0;
        check("to.err_cleared", 32'(t_err), 32'd0);
        check("to.di_cleared", 32'(t_di), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
